// File: rtl/traffic_generator_if.sv
// AXI4-Stream bundle used by the traffic generator.
// The master drives data, byte enables, valid and last; the slave drives ready.
interface traffic_generator_if #(
    parameter int WIDTH = 256
);
    logic [WIDTH-1:0]   TDATA;
    logic [WIDTH/8-1:0] TKEEP;
    logic               TVALID;
    logic               TREADY;
    logic               TLAST;

    modport master (
        output TDATA,
        output TKEEP,
        output TVALID,
        output TLAST,
        input  TREADY
    );

    modport slave (
        input  TDATA,
        input  TKEEP,
        input  TVALID,
        input  TLAST,
        output TREADY
    );
endinterface

// File: rtl/traffic_generator.sv
// AXI4-Stream traffic source.
// Emits a programmed number of fixed-length packets with a selectable data
// pattern, a partial last beat and optional M-beats-then-N-idle rate limiting.
// Configuration is captured when a run starts; all stream outputs are registered.
module traffic_generator #(
    parameter int WIDTH      = 256,
    parameter int RESET_TYPE = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [5:0]          mode,
    input  logic [15:0]         num_packets,
    input  logic [15:0]         num_flits,
    input  logic [7:0]          last_flit_bytes,
    input  logic [15:0]         M,
    input  logic [15:0]         N,
    traffic_generator_if.master axis
);

    localparam int BYTES = WIDTH / 8;
    localparam int LANES = WIDTH / 32;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_GAP  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // One step of the x^32+x^22+x^2+x+1 Fibonacci LFSR (taps 32,22,2,1).
    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
    endfunction

    // A packet length of zero behaves as a single beat.
    function automatic logic [15:0] norm_flits(input logic [15:0] v);
        if (v == 16'd0) begin
            return 16'd1;
        end else begin
            return v;
        end
    endfunction

    // Zero or an oversized byte count means a full last beat.
    function automatic logic [15:0] norm_bytes(input logic [7:0] v);
        if ((v == 8'd0) || ({8'd0, v} > 16'(BYTES))) begin
            return 16'(BYTES);
        end else begin
            return {8'd0, v};
        end
    endfunction

    // Byte enables: all ones except on the last beat, where only the low lfb bytes are set.
    function automatic logic [BYTES-1:0] make_keep(input logic last, input logic [15:0] lfb);
        logic [BYTES-1:0] k;
        for (int b = 0; b < BYTES; b++) begin
            k[b] = !last || (16'(b) < lfb);
        end
        return k;
    endfunction

    // Fill every 32-bit lane with the selected pattern, then zero disabled bytes.
    function automatic logic [WIDTH-1:0] make_data(
        input logic [1:0]       pat,
        input logic [15:0]      pkt,
        input logic [15:0]      flit,
        input logic [31:0]      beat,
        input logic [31:0]      lfsr,
        input logic [BYTES-1:0] keep
    );
        logic [WIDTH-1:0] d;
        logic [31:0]      lane;
        for (int l = 0; l < LANES; l++) begin
            case (pat)
                2'b00:   lane = beat;
                2'b01:   lane = {pkt, flit};
                2'b10:   lane = lfsr;
                default: lane = 32'(l);
            endcase
            d[l*32 +: 32] = lane;
        end
        for (int b = 0; b < BYTES; b++) begin
            if (!keep[b]) begin
                d[b*8 +: 8] = 8'd0;
            end
        end
        return d;
    endfunction

    // FSM state and datapath registers
    state_t      state_r;
    logic [15:0] np_r, nf_r, lfb_r, m_r, n_r;
    logic        cont_r, rl_r;
    logic [1:0]  pat_r;
    logic [15:0] pkt_r, flit_r, burst_r, gap_r;
    logic [31:0] beat_r, lfsr_r;

    // next values
    state_t      state_s;
    logic [15:0] np_s, nf_s, lfb_s, m_s, n_s;
    logic        cont_s, rl_s;
    logic [1:0]  pat_s;
    logic [15:0] pkt_s, flit_s, burst_s, gap_s;
    logic [31:0] beat_s, lfsr_s;

    // registered stream outputs and their next values
    logic             tvalid_r, tlast_r;
    logic [WIDTH-1:0] tdata_r;
    logic [BYTES-1:0] tkeep_r;
    logic             valid_s, last_s, last_calc_s;
    logic [WIDTH-1:0] data_s, data_calc_s;
    logic [BYTES-1:0] keep_s, keep_calc_s;

    logic hs_s, last_flit_s, rl_act_s, burst_hit_s;
    logic unused_s;

    assign hs_s        = tvalid_r & axis.TREADY;
    assign last_flit_s = (flit_r == (nf_r - 16'd1));
    assign rl_act_s    = rl_r && (m_r != 16'd0) && (n_r != 16'd0);
    assign burst_hit_s = rl_act_s && ((burst_r + 16'd1) == m_r);
    // mode[5] is reserved; only active-high reset exists
    assign unused_s    = mode[5] ^ (RESET_TYPE != 1);

    // Next-state and counter logic.
    always_comb begin
        state_s = state_r;
        np_s    = np_r;
        nf_s    = nf_r;
        lfb_s   = lfb_r;
        m_s     = m_r;
        n_s     = n_r;
        cont_s  = cont_r;
        rl_s    = rl_r;
        pat_s   = pat_r;
        pkt_s   = pkt_r;
        flit_s  = flit_r;
        beat_s  = beat_r;
        lfsr_s  = lfsr_r;
        burst_s = burst_r;
        gap_s   = gap_r;
        case (state_r)
            S_IDLE: begin
                if (mode[0]) begin
                    np_s    = num_packets;
                    nf_s    = norm_flits(num_flits);
                    lfb_s   = norm_bytes(last_flit_bytes);
                    m_s     = M;
                    n_s     = N;
                    cont_s  = mode[1];
                    rl_s    = mode[2];
                    pat_s   = mode[4:3];
                    pkt_s   = 16'd0;
                    flit_s  = 16'd0;
                    beat_s  = 32'd0;
                    lfsr_s  = 32'hFFFF_FFFF;
                    burst_s = 16'd0;
                    gap_s   = 16'd0;
                    if (!mode[1] && (num_packets == 16'd0)) begin
                        state_s = S_DONE;
                    end else begin
                        state_s = S_RUN;
                    end
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_RUN: begin
                if (hs_s) begin
                    beat_s = beat_r + 32'd1;
                    lfsr_s = lfsr_step(lfsr_r);
                    gap_s  = 16'd0;
                    if (!rl_act_s) begin
                        burst_s = burst_r;
                    end else if (burst_hit_s) begin
                        burst_s = 16'd0;
                    end else begin
                        burst_s = burst_r + 16'd1;
                    end
                    if (last_flit_s) begin
                        // end of packet: run completion and stop take priority over a gap
                        flit_s = 16'd0;
                        pkt_s  = pkt_r + 16'd1;
                        if (!cont_r && ((pkt_r + 16'd1) == np_r)) begin
                            state_s = S_DONE;
                        end else if (!mode[0]) begin
                            state_s = S_IDLE;
                        end else if (burst_hit_s) begin
                            state_s = S_GAP;
                        end else begin
                            state_s = S_RUN;
                        end
                    end else begin
                        flit_s = flit_r + 16'd1;
                        if (burst_hit_s) begin
                            state_s = S_GAP;
                        end else begin
                            state_s = S_RUN;
                        end
                    end
                end else begin
                    state_s = S_RUN;
                end
            end
            S_GAP: begin
                if (gap_r == (n_r - 16'd1)) begin
                    gap_s   = 16'd0;
                    state_s = S_RUN;
                end else begin
                    gap_s   = gap_r + 16'd1;
                    state_s = S_GAP;
                end
            end
            S_DONE: begin
                if (!mode[0]) begin
                    state_s = S_IDLE;
                end else begin
                    state_s = S_DONE;
                end
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase
    end

    // Next output beat: load a fresh beat on entry to RUN or after a handshake, hold on stall.
    always_comb begin
        last_calc_s = (flit_s == (nf_s - 16'd1));
        keep_calc_s = make_keep(last_calc_s, lfb_s);
        data_calc_s = make_data(pat_s, pkt_s, flit_s, beat_s, lfsr_s, keep_calc_s);
        valid_s     = tvalid_r;
        last_s      = tlast_r;
        keep_s      = tkeep_r;
        data_s      = tdata_r;
        if (state_s != S_RUN) begin
            valid_s = 1'b0;
            last_s  = 1'b0;
            keep_s  = '0;
            data_s  = '0;
        end else if ((state_r != S_RUN) || hs_s) begin
            valid_s = 1'b1;
            last_s  = last_calc_s;
            keep_s  = keep_calc_s;
            data_s  = data_calc_s;
        end else begin
            valid_s = tvalid_r;
            last_s  = tlast_r;
            keep_s  = tkeep_r;
            data_s  = tdata_r;
        end
    end

    // State, latched configuration and counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= S_IDLE;
            np_r    <= 16'd0;
            nf_r    <= 16'd0;
            lfb_r   <= 16'd0;
            m_r     <= 16'd0;
            n_r     <= 16'd0;
            cont_r  <= 1'b0;
            rl_r    <= 1'b0;
            pat_r   <= 2'b00;
            pkt_r   <= 16'd0;
            flit_r  <= 16'd0;
            beat_r  <= 32'd0;
            lfsr_r  <= 32'd0;
            burst_r <= 16'd0;
            gap_r   <= 16'd0;
        end else begin
            state_r <= state_s;
            np_r    <= np_s;
            nf_r    <= nf_s;
            lfb_r   <= lfb_s;
            m_r     <= m_s;
            n_r     <= n_s;
            cont_r  <= cont_s;
            rl_r    <= rl_s;
            pat_r   <= pat_s;
            pkt_r   <= pkt_s;
            flit_r  <= flit_s;
            beat_r  <= beat_s;
            lfsr_r  <= lfsr_s;
            burst_r <= burst_s;
            gap_r   <= gap_s;
        end
    end

    // Stream output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tvalid_r <= 1'b0;
            tlast_r  <= 1'b0;
            tkeep_r  <= '0;
            tdata_r  <= '0;
        end else begin
            tvalid_r <= valid_s;
            tlast_r  <= last_s;
            tkeep_r  <= keep_s;
            tdata_r  <= data_s;
        end
    end

    assign axis.TVALID = tvalid_r;
    assign axis.TLAST  = tlast_r;
    assign axis.TKEEP  = tkeep_r;
    assign axis.TDATA  = tdata_r;

endmodule

// File: tb/tb_traffic_generator.sv
// Bench for traffic_generator: a table of run configurations plus hand-written
// sequences for rate limiting, graceful stop, empty runs and mid-packet reset.
// A reference model pushes expected beats into a queue when a run is started;
// a monitor pops and compares on every handshake.
module tb_traffic_generator;
    localparam int WIDTH = 256;
    localparam int BYTES = WIDTH / 8;
    localparam int LANES = WIDTH / 32;
    localparam int BW    = WIDTH + BYTES + 1;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  mode;
    logic [15:0] num_packets, num_flits, M, N;
    logic [7:0]  last_flit_bytes;

    traffic_generator_if #(.WIDTH(WIDTH)) axis();

    traffic_generator #(.WIDTH(WIDTH), .RESET_TYPE(1)) dut (
        .clk            (clk),
        .rst            (rst),
        .mode           (mode),
        .num_packets    (num_packets),
        .num_flits      (num_flits),
        .last_flit_bytes(last_flit_bytes),
        .M              (M),
        .N              (N),
        .axis           (axis)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0] md;
        int         np;
        int         nf;
        int         lfb;
        int         m;
        int         n;
        int         rdy;
        int         exp_beats;
    } vec_t;

    int              n_checks = 0;
    int              n_pass   = 0;
    int              rx_count = 0;
    int              rdy_mode = 0;
    logic [BW-1:0]   exp_q[$];
    logic            prev_v, prev_r;
    logic [BW-1:0]   prev_b, want_b;

    task automatic check(input string name, input logic [319:0] act, input logic [319:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [BW-1:0] dut_beat();
        return {axis.TLAST, axis.TKEEP, axis.TDATA};
    endfunction

    // Reference model: walk packets and flits, generating every expected beat.
    function automatic void push_model(input logic [5:0] md, input int nf, input int lfb, input int npk);
        int               nf_e, lfb_e;
        logic [31:0]      cnt, lf, lane;
        logic [BYTES-1:0] keep;
        logic [WIDTH-1:0] data;
        logic             last;
        nf_e  = (nf == 0) ? 1 : nf;
        lfb_e = (lfb == 0 || lfb > BYTES) ? BYTES : lfb;
        cnt   = 32'd0;
        lf    = 32'hFFFF_FFFF;
        for (int p = 0; p < npk; p++) begin
            for (int f = 0; f < nf_e; f++) begin
                last = (f == nf_e - 1);
                for (int b = 0; b < BYTES; b++) keep[b] = !last || (b < lfb_e);
                for (int l = 0; l < LANES; l++) begin
                    case (md[4:3])
                        2'b00:   lane = cnt;
                        2'b01:   lane = {16'(p), 16'(f)};
                        2'b10:   lane = lf;
                        default: lane = 32'(l);
                    endcase
                    data[l*32 +: 32] = lane;
                end
                for (int b = 0; b < BYTES; b++) if (!keep[b]) data[b*8 +: 8] = 8'd0;
                exp_q.push_back({last, keep, data});
                cnt = cnt + 32'd1;
                lf  = {lf[30:0], ^(lf & 32'h8020_0003)};
            end
        end
    endfunction

    // Sink ready pattern: always, alternating, or random.
    initial begin
        axis.TREADY = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       axis.TREADY = 1'b1;
                1:       axis.TREADY = ~axis.TREADY;
                default: axis.TREADY = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: AXI hold rule on stalls and scoreboard compare on handshakes.
    initial begin
        prev_v = 1'b0;
        prev_r = 1'b0;
        prev_b = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_v = 1'b0;
                prev_r = 1'b0;
            end else begin
                if (prev_v && !prev_r)
                    check("stall_hold", {30'd0, axis.TVALID, dut_beat()}, {30'd0, 1'b1, prev_b});
                if (axis.TVALID && axis.TREADY) begin
                    rx_count++;
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL extra_beat: got %h expected no beat", dut_beat());
                    end else begin
                        want_b = exp_q.pop_front();
                        check("beat", 320'(dut_beat()), 320'(want_b));
                    end
                end
                prev_v = axis.TVALID;
                prev_r = axis.TREADY;
                prev_b = dut_beat();
            end
        end
    end

    task automatic wait_beats(input int n, input int budget);
        int left;
        left = budget;
        while (rx_count < n && left > 0) begin
            @(negedge clk);
            #1;
            left--;
        end
        if (rx_count < n) check("beat_timeout", 320'(rx_count), 320'(n));
    endtask

    task automatic start_run(input logic [5:0] md, input int np, input int nf, input int lfb,
                             input int m, input int n, input int npk, input logic exp_v);
        rx_count = 0;
        push_model(md, nf, lfb, npk);
        @(posedge clk);
        #1;
        mode            = md;
        num_packets     = 16'(np);
        num_flits       = 16'(nf);
        last_flit_bytes = 8'(lfb);
        M               = 16'(m);
        N               = 16'(n);
        @(negedge clk);
        check("pre_start_valid", 320'(axis.TVALID), 320'(1'b0));
        @(negedge clk);
        check("first_beat_valid", 320'(axis.TVALID), 320'(exp_v));
    endtask

    task automatic finish_run(input int exp_beats, input bit drain);
        int vcount;
        wait_beats(exp_beats, 500);
        vcount = 0;
        repeat (5) begin
            @(negedge clk);
            if (axis.TVALID) vcount++;
        end
        check("tail_idle", 320'(vcount), 320'(0));
        check("beat_count", 320'(rx_count), 320'(exp_beats));
        if (drain) check("queue_drained", 320'(exp_q.size()), 320'(0));
        exp_q.delete();
        @(posedge clk);
        #1;
        mode = 6'd0;
        repeat (3) @(posedge clk);
    endtask

    vec_t        vt[6];
    logic [12:0] vbits;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = '{6'b000001, 2, 3, 5,  0, 0, 0, 6};
        vt[1] = '{6'b000001, 2, 3, 5,  0, 0, 1, 6};
        vt[2] = '{6'b010001, 1, 4, 0,  0, 0, 2, 4};
        vt[3] = '{6'b011001, 3, 1, 40, 0, 0, 0, 3};
        vt[4] = '{6'b001001, 2, 0, 1,  0, 0, 1, 2};
        vt[5] = '{6'b100101, 2, 4, 8,  3, 2, 2, 8};

        rst = 1'b1;
        mode = 6'd0;
        num_packets = 16'd0;
        num_flits = 16'd0;
        last_flit_bytes = 8'd0;
        M = 16'd0;
        N = 16'd0;
        repeat (3) @(posedge clk);
        #2;
        check("reset_tvalid", 320'(axis.TVALID), 320'(1'b0));
        check("reset_tlast",  320'(axis.TLAST),  320'(1'b0));
        check("reset_tkeep",  320'(axis.TKEEP),  320'(0));
        check("reset_tdata",  320'(axis.TDATA),  320'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);

        for (int i = 0; i < 6; i++) begin
            rdy_mode = vt[i].rdy;
            start_run(vt[i].md, vt[i].np, vt[i].nf, vt[i].lfb, vt[i].m, vt[i].n, vt[i].np, 1'b1);
            finish_run(vt[i].exp_beats, 1'b1);
        end

        // rate limit M=2 N=3: two beats, three idle cycles, repeated
        rdy_mode = 0;
        start_run(6'b000101, 1, 6, 0, 2, 3, 1, 1'b1);
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            vbits[i] = axis.TVALID;
        end
        check("rate_limit_pattern", 320'(vbits), 320'(13'b0011000110001));
        finish_run(6, 1'b1);

        // continuous {pkt,flit} pattern, enable dropped mid-packet
        rdy_mode = 0;
        start_run(6'b001011, 0, 3, 4, 0, 0, 3, 1'b1);
        wait_beats(4, 100);
        mode = 6'b001010;
        finish_run(6, 1'b0);

        // zero packets: no beats, sits in DONE
        start_run(6'b000001, 0, 3, 5, 0, 0, 0, 1'b0);
        finish_run(0, 1'b1);

        // reset during the second beat, then a clean restart
        rdy_mode = 0;
        start_run(6'b000001, 2, 3, 5, 0, 0, 2, 1'b1);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("rst_mid_tvalid", 320'(axis.TVALID), 320'(1'b0));
        check("rst_mid_tkeep",  320'(axis.TKEEP),  320'(0));
        check("rst_mid_tdata",  320'(axis.TDATA),  320'(0));
        exp_q.delete();
        mode = 6'd0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        start_run(6'b000001, 2, 3, 5, 0, 0, 2, 1'b1);
        finish_run(6, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/traffic_generator.md
# traffic_generator

Parameterised AXI4-Stream traffic source (DUT name `tg`) used to drive stress and bring-up traffic into stream sinks. Software or a bench drives static configuration words; the block emits a programmed number of fixed-length packets with a chosen data pattern, partial last beat and optional rate limiting. Output is a single AXI-Stream master with TDATA/TKEEP/TVALID/TREADY/TLAST.

## Interface
- WIDTH, 256: TDATA width in bits; multiple of 32, minimum 32. TKEEP is WIDTH/8 bits.
- RESET_TYPE, 1: reset polarity selector. Only 1 (active-high) is supported; other values are reserved.
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- mode  in  6  bit0 enable; bit1 continuous; bit2 rate-limit enable; bits4:3 data pattern; bit5 reserved, ignored.
- num_packets  in  16  packets per run (ignored when continuous).
- num_flits  in  16  beats per packet; 0 is treated as 1.
- last_flit_bytes  in  8  valid bytes in the last beat; 0 or >WIDTH/8 means WIDTH/8.
- M  in  16  beats accepted per burst when rate limiting is enabled.
- N  in  16  idle cycles inserted after each M-beat burst.
- TDATA  out  WIDTH  stream data.
- TKEEP  out  WIDTH/8  byte enables, contiguous from byte 0.
- TVALID  out  1  beat valid.
- TREADY  in  1  sink ready.
- TLAST  out  1  last beat of packet.

## Operation
- States: IDLE, RUN, GAP, DONE.
- IDLE: if mode[0]=1, latch num_packets, num_flits, last_flit_bytes, M, N and mode[4:1]; clear packet, flit and beat counters; seed LFSR to 0xFFFFFFFF; go to RUN. Later changes to these inputs are ignored until the next IDLE, except mode[0].
- Non-continuous run with latched num_packets=0: go directly to DONE; no beats are sent.
- RUN: present a beat. Advance on handshake (TVALID&TREADY): increment flit index; on the last flit, reset the flit index and increment the packet index.
- End of packet:
  - non-continuous and all packets sent: go to DONE;
  - mode[0]=0: go to IDLE (graceful stop; packets are never truncated);
  - otherwise continue.
- Rate limiting (latched mode[2]=1, M≠0, N≠0): count accepted beats across packet boundaries. After the M-th beat, enter GAP for exactly N cycles with TVALID=0, then resume RUN. End-of-packet checks still apply at the M-th beat.
- DONE: TVALID=0; return to IDLE when mode[0]=0.
- TKEEP: all ones on non-last beats. On the last beat, the low last_flit_bytes bits are set and the rest clear.
- TDATA bytes whose TKEEP bit is 0 are driven 0.
- Patterns (mode[4:3]), applied to every 32-bit lane:
  - 00: beat counter (0 at start, +1 per accepted beat, wraps at 2^32).
  - 01: {packet_index[15:0], flit_index[15:0]}.
  - 10: 32-bit Fibonacci LFSR, x^32+x^22+x^2+x+1, advanced per accepted beat.
  - 11: lane number i (lane 0 = bits 31:0).
- Counter wrap: packet index wraps at 16 bits in continuous mode.

## Timing
- Reset (asynchronous): TVALID=0, TLAST=0, TKEEP=0, TDATA=0, state IDLE, all counters 0.
- All outputs are registered. The first beat is presented in the cycle after the edge at which mode[0]=1 is sampled in IDLE.
- AXI rules: once TVALID=1, TDATA/TKEEP/TLAST hold until the handshake. TVALID never drops without a handshake; gaps occur only between beats.
- With TREADY=1 and no rate limiting: one beat per cycle, no bubbles between packets.
- The last beat of a run is followed by TVALID=0 in the next cycle.
- TREADY low stalls indefinitely with no loss or duplication.
- Reset asserted mid-packet: outputs clear immediately. No resume; a new start is required.

## Test plan
- WIDTH=256, mode=0b00001, num_packets=2, num_flits=3, last_flit_bytes=5, TREADY=1 -> 6 consecutive beats; TLAST on beats 3 and 6; TKEEP=0x1F on last beats, 0xFFFFFFFF otherwise; lane data 0..5; then DONE.
- Same configuration with TREADY toggling 1,0,1,0 -> same 6 beats; outputs stable during stalls; no duplicates.
- mode=0b00101, M=2, N=3, num_packets=1, num_flits=6 -> pattern of 2 valid, 3 idle repeated; 6 beats total.
- mode=0b01011 (continuous, pattern 01), then drop mode[0] mid-packet -> current packet completes with TLAST; lanes read {pkt,flit}; returns to IDLE.
- num_packets=0, mode[0]=1 -> no TVALID; DONE until mode[0]=0.
- Assert rst during beat 2 -> TVALID=0, TKEEP=0 immediately; restart yields a beat counter starting at 0.
